// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the regfile_sb register file and scoreboard.
// No logic; compile-time only.
// No flow control.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_MAX   = 4;
    localparam int ZERO_REG  = 0;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per register, register 0 never busy.
// Set/clear take effect at the next clk edge; busy_vec is a direct register output.
// No backpressure: set and clear are accepted every cycle.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_set_en,
    input  logic [AW-1:0]    i_set_addr,
    input  logic             i_clr_en,
    input  logic [AW-1:0]    i_clr_addr,
    output logic [NREGS-1:0] o_busy_vec
);

    localparam logic [AW-1:0] ZA = AW'(ZERO_REG);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;
    logic [NREGS-1:0] w_busy_nxt;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (i_set_en && (i_set_addr != ZA)) begin
            w_set[i_set_addr] = 1'b1;
        end
        if (i_clr_en && (i_clr_addr != ZA)) begin
            w_clr[i_clr_addr] = 1'b1;
        end
        // Set is applied after clear so a back-to-back issue to the same
        // destination keeps the register pending.
        w_busy_nxt    = (r_busy & ~w_clr) | w_set;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_busy_vec = r_busy;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with hardwired zero register and busy scoreboard.
// Reads are combinational; writes land on the clk edge (same-cycle bypass with REGFILE_BYPASS_EN).
// No backpressure: every read, write and busy-set is accepted each cycle.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int AW    = clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                bs_en,
    input  logic [AW-1:0]       bs_addr,
    output logic [NREGS-1:0]    busy_vec
);

    localparam logic [AW-1:0] ZA = AW'(ZERO_REG);

    if ((NRD < 1) || (NRD > NRD_MAX)) begin : g_bad_nrd
        $error("regfile_sb: NRD out of range");
    end

    logic [XLEN-1:0]  r_rf [NREGS];
    logic [NREGS-1:0] w_busy_vec;
    logic             w_wr_ok;

    assign w_wr_ok = wr_en && (wr_addr != ZA);

    // Entry 0 is never written, so it holds its reset value of zero forever.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_rf[wr_addr] <= wr_data;
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_set_en   (bs_en),
        .i_set_addr (bs_addr),
        .i_clr_en   (wr_en),
        .i_clr_addr (wr_addr),
        .o_busy_vec (w_busy_vec)
    );

    assign busy_vec = w_busy_vec;

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] w_ra;
        assign w_ra = rd_addr[g*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        logic w_hit;
        assign w_hit = w_wr_ok && (w_ra == wr_addr);
        assign rd_data[g*XLEN +: XLEN] = w_hit ? wr_data : r_rf[w_ra];
        assign rd_busy[g] = w_hit ? (bs_en && (bs_addr == wr_addr)) : w_busy_vec[w_ra];
`else
        assign rd_data[g*XLEN +: XLEN] = r_rf[w_ra];
        assign rd_busy[g] = w_busy_vec[w_ra];
`endif
    end

endmodule
